// File: rtl/rx_filt_pkg.sv
// Shared types and constants for the receive matched filter.
// RX_COEF is a symmetric 17-tap pulse-shaping response in 1s17.
package rx_filt_pkg;

    localparam int unsigned RX_SAMPLE_W    = 18;
    localparam int unsigned RX_NUM_TAPS    = 17;
    localparam int unsigned RX_NUM_PAIRS   = 8;
    localparam int unsigned RX_PREADD_W    = 19;
    localparam int unsigned RX_PROD_W      = 37;
    localparam int unsigned RX_ACC_W       = 41;
    localparam int unsigned RX_FRAC_W      = 17;
    localparam int unsigned RX_PHASE_W     = 2;
    localparam int          RX_SLICER_THR  = 65536;

    typedef logic signed [RX_SAMPLE_W-1:0] sample_t;

    // Valid flag and symbol phase travelling alongside each pipeline stage
    typedef struct packed {
        logic                  vld;
        logic [RX_PHASE_W-1:0] ph;
    } rx_tag_t;

    localparam sample_t RX_COEF [0:RX_NUM_TAPS-1] = '{
        sample_t'(-1001), sample_t'(-2003), sample_t'(0),     sample_t'(4001),
        sample_t'(8000),  sample_t'(16385), sample_t'(24000), sample_t'(30001),
        sample_t'(32767),
        sample_t'(30001), sample_t'(24000), sample_t'(16385), sample_t'(8000),
        sample_t'(4001),  sample_t'(0),     sample_t'(-2003), sample_t'(-1001)
    };

    // 4-ASK decision: 00 strong negative, 01 weak negative, 10 weak positive, 11 strong positive
    function automatic logic [1:0] rx_slice(input sample_t s);
        if (s < -RX_SLICER_THR)
            return 2'b00;
        else if (s < 0)
            return 2'b01;
        else if (s < RX_SLICER_THR)
            return 2'b10;
        else
            return 2'b11;
    endfunction

endpackage

// File: rtl/rx_round_sat.sv
// Rounds a 41-bit accumulator (2^-17 LSB) half-up to 1s17 and saturates to the sample range.
module rx_round_sat
    import rx_filt_pkg::*;
(
    input  logic signed [RX_ACC_W-1:0]    acc,
    output logic signed [RX_SAMPLE_W-1:0] y_c
);

    localparam int unsigned Q_W = RX_ACC_W - RX_FRAC_W;
    localparam logic signed [Q_W-1:0] Q_MAX = Q_W'(131071);
    localparam logic signed [Q_W-1:0] Q_MIN = Q_W'(-131072);

    logic signed [RX_ACC_W-1:0] rnd_c;
    logic signed [Q_W-1:0]      q_c;

    always_comb begin
        rnd_c = acc + RX_ACC_W'(65536);
        q_c   = Q_W'(rnd_c >>> RX_FRAC_W);
        if (q_c > Q_MAX)
            y_c = RX_SAMPLE_W'(131071);
        else if (q_c < Q_MIN)
            y_c = RX_SAMPLE_W'(-131072);
        else
            y_c = q_c[RX_SAMPLE_W-1:0];
    end

endmodule

// File: rtl/rx_matched_filt.sv
// 17-tap folded matched filter with symbol decimation and optional 4-ASK slicer.
// Define RX_SLICER_EN to build the slicer; otherwise dec is tied to 2'b00.
module rx_matched_filt
    import rx_filt_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sam_en,
    input  logic signed [RX_SAMPLE_W-1:0] x_in,
    input  logic [RX_PHASE_W-1:0]         sym_phase,
    output logic signed [RX_SAMPLE_W-1:0] y,
    output logic                          y_valid,
    output logic signed [RX_SAMPLE_W-1:0] sym_out,
    output logic                          sym_valid,
    output logic [1:0]                    dec
);

    sample_t                    taps [RX_NUM_TAPS];
    logic signed [RX_PREADD_W-1:0] pre  [RX_NUM_PAIRS+1];
    logic signed [RX_PROD_W-1:0]   prod [RX_NUM_PAIRS+1];
    logic signed [RX_ACC_W-1:0]    acc_c;
    logic signed [RX_ACC_W-1:0]    sum_q;
    logic signed [RX_SAMPLE_W-1:0] rs_c;
    logic [RX_PHASE_W-1:0]         ph_cnt;
    rx_tag_t                       tap_tag, pre_tag, mul_tag, sum_tag;
    logic                          hit_c;

    // Delay line and phase counter move only on the sample strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RX_NUM_TAPS; i++) taps[i] <= '0;
            ph_cnt  <= '0;
            tap_tag <= '0;
        end else begin
            tap_tag <= '{vld: sam_en, ph: ph_cnt};
            if (sam_en) begin
                taps[0] <= x_in;
                for (int i = 1; i < RX_NUM_TAPS; i++) taps[i] <= taps[i-1];
                ph_cnt <= ph_cnt + RX_PHASE_W'(1);
            end
        end
    end

    // Pre-add, multiply and sum stages advance every clock
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= RX_NUM_PAIRS; i++) begin
                pre[i]  <= '0;
                prod[i] <= '0;
            end
            sum_q   <= '0;
            pre_tag <= '0;
            mul_tag <= '0;
            sum_tag <= '0;
        end else begin
            for (int i = 0; i < RX_NUM_PAIRS; i++)
                pre[i] <= RX_PREADD_W'(taps[i]) + RX_PREADD_W'(taps[RX_NUM_TAPS-1-i]);
            pre[RX_NUM_PAIRS] <= RX_PREADD_W'(taps[RX_NUM_PAIRS]);
            for (int i = 0; i <= RX_NUM_PAIRS; i++)
                prod[i] <= RX_PROD_W'(pre[i]) * RX_PROD_W'(RX_COEF[i]);
            sum_q   <= acc_c;
            pre_tag <= tap_tag;
            mul_tag <= pre_tag;
            sum_tag <= mul_tag;
        end
    end

    always_comb begin
        acc_c = '0;
        for (int i = 0; i <= RX_NUM_PAIRS; i++) acc_c = acc_c + RX_ACC_W'(prod[i]);
    end

    rx_round_sat u_round_sat (
        .acc (sum_q),
        .y_c (rs_c)
    );

    assign hit_c = sum_tag.vld && (sum_tag.ph == sym_phase);

    // Output stage: full-rate sample plus the decimated symbol
    always_ff @(posedge clk) begin
        if (reset) begin
            y         <= '0;
            y_valid   <= 1'b0;
            sym_out   <= '0;
            sym_valid <= 1'b0;
        end else begin
            y_valid   <= sum_tag.vld;
            sym_valid <= hit_c;
            if (sum_tag.vld) y <= rs_c;
            if (hit_c) sym_out <= rs_c;
        end
    end

`ifdef RX_SLICER_EN
    always_ff @(posedge clk) begin
        if (reset)
            dec <= 2'b00;
        else if (hit_c)
            dec <= rx_slice(rs_c);
    end
`else
    assign dec = 2'b00;
`endif

endmodule

// File: tb/tb_rx_matched_filt.sv
// Directed self-checking bench for rx_matched_filt (slicer checks follow RX_SLICER_EN).
module tb_rx_matched_filt;

    logic               clk = 1'b0;
    logic               reset;
    logic               sam_en;
    logic signed [17:0] x_in;
    logic [1:0]         sym_phase;
    logic signed [17:0] y;
    logic               y_valid;
    logic signed [17:0] sym_out;
    logic               sym_valid;
    logic [1:0]         dec;

    int errors = 0;
    int checks = 0;

    localparam int COEF [17] = '{-1001, -2003, 0, 4001, 8000, 16385, 24000, 30001, 32767,
                                 30001, 24000, 16385, 8000, 4001, 0, -2003, -1001};
    // floor((c[k]+1)/2): response to a 0.5 impulse
    localparam int IMP [17]  = '{-500, -1001, 0, 2001, 4000, 8193, 12000, 15001, 16384,
                                 15001, 12000, 8193, 4000, 2001, 0, -1001, -500};
    localparam int SINE [8]  = '{0, 46341, 65536, 46341, 0, -46341, -65536, -46341};

    rx_matched_filt dut (
        .clk       (clk),
        .reset     (reset),
        .sam_en    (sam_en),
        .x_in      (x_in),
        .sym_phase (sym_phase),
        .y         (y),
        .y_valid   (y_valid),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .dec       (dec)
    );

    always #5 clk = ~clk;

    task automatic do_reset(input int n);
        @(negedge clk);
        reset  = 1'b1;
        sam_en = 1'b0;
        x_in   = '0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(21);
        checks++; if (y !== 18'sd0) begin errors++; $display("FAIL reset_y: got %0d want 0", y); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid: got %b want 0", y_valid); end
        checks++; if (sym_out !== 18'sd0) begin errors++; $display("FAIL reset_sym_out: got %0d want 0", sym_out); end
        checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL reset_sym_valid: got %b want 0", sym_valid); end
        checks++; if (dec !== 2'b00) begin errors++; $display("FAIL reset_dec: got %b want 00", dec); end
    endtask

    task automatic test_impulse();
        logic signed [17:0] exp_y;
        do_reset(21);
        sym_phase = 2'd0;
        for (int d = 0; d < 25; d++) begin
            sam_en = 1'b1;
            x_in   = (d == 0) ? 18'sd65536 : 18'sd0;
            @(negedge clk);
            checks++;
            if (y_valid !== (d >= 4)) begin
                errors++; $display("FAIL impulse_valid d=%0d: got %b want %b", d, y_valid, (d >= 4));
            end
            if (d >= 4) begin
                exp_y = (d - 4 < 17) ? 18'(IMP[d-4]) : 18'sd0;
                checks++;
                if (y !== exp_y) begin
                    errors++; $display("FAIL impulse_y k=%0d: got %0d want %0d", d - 4, y, exp_y);
                end
            end
        end
        sam_en = 1'b0;
    endtask

    task automatic test_gaps();
        logic signed [17:0] exp_y;
        logic               exp_v;
        int                 k;
        do_reset(3);
        for (int d = 0; d < 58; d++) begin
            sam_en = (d % 3 == 0);
            x_in   = (d == 0) ? 18'sd65536 : 18'sd0;
            @(negedge clk);
            exp_v = (d >= 4) && ((d - 4) % 3 == 0);
            checks++;
            if (y_valid !== exp_v) begin
                errors++; $display("FAIL gaps_valid d=%0d: got %b want %b", d, y_valid, exp_v);
            end
            if (exp_v) begin
                k     = (d - 4) / 3;
                exp_y = (k < 17) ? 18'(IMP[k]) : 18'sd0;
                checks++;
                if (y !== exp_y) begin
                    errors++; $display("FAIL gaps_y k=%0d: got %0d want %0d", k, y, exp_y);
                end
            end
        end
        sam_en = 1'b0;
    endtask

    task automatic test_saturation();
        logic signed [17:0] exp_y;
        for (int pol = 0; pol < 2; pol++) begin
            do_reset(3);
            for (int j = 0; j < 17; j++) begin
                sam_en = 1'b1;
                x_in   = ((COEF[16-j] >= 0) ^ (pol == 1)) ? 18'sd131071 : -18'sd131072;
                @(negedge clk);
            end
            sam_en = 1'b0;
            x_in   = '0;
            repeat (6) @(negedge clk);
            exp_y = (pol == 0) ? 18'sd131071 : -18'sd131072;
            checks++;
            if (y !== exp_y) begin
                errors++; $display("FAIL saturate_y pol=%0d: got %0d want %0d", pol, y, exp_y);
            end
            checks++;
            if (y_valid !== 1'b0) begin
                errors++; $display("FAIL saturate_idle_valid pol=%0d: got %b want 0", pol, y_valid);
            end
        end
    endtask

    task automatic test_decimation();
        logic signed [17:0] exp_y;
        logic signed [17:0] exp_sym;
        logic               exp_s;
        int                 idx;
        int                 first_pulse;
        do_reset(3);
        sym_phase   = 2'd2;
        idx         = 0;
        first_pulse = -1;
        exp_sym     = '0;
        for (int d = 0; d < 45; d++) begin
            sam_en = (d <= 40);
            x_in   = (d == 0 || d == 20) ? 18'sd65536 : 18'sd0;
            if (d == 22) sym_phase = 2'd0;
            @(negedge clk);
            if (y_valid === 1'b1) begin
                exp_y = '0;
                if (idx < 17) exp_y = 18'(IMP[idx]);
                else if (idx >= 20 && idx < 37) exp_y = 18'(IMP[idx-20]);
                exp_s = (2'(idx) == sym_phase);
                if (exp_s) exp_sym = exp_y;
                if (exp_s && first_pulse < 0) first_pulse = idx;
                checks++;
                if (sym_valid !== exp_s) begin
                    errors++; $display("FAIL decim_pulse idx=%0d: got %b want %b", idx, sym_valid, exp_s);
                end
                idx++;
            end else begin
                checks++;
                if (sym_valid !== 1'b0) begin
                    errors++; $display("FAIL decim_stray d=%0d: got %b want 0", d, sym_valid);
                end
            end
            checks++;
            if (sym_out !== exp_sym) begin
                errors++; $display("FAIL decim_sym_out d=%0d: got %0d want %0d", d, sym_out, exp_sym);
            end
        end
        checks++;
        if (first_pulse !== 2) begin
            errors++; $display("FAIL decim_first: got %0d want 2", first_pulse);
        end
        sam_en = 1'b0;
    endtask

    task automatic test_reset_midstream();
        do_reset(3);
        sym_phase = 2'd0;
        for (int d = 0; d < 10; d++) begin
            sam_en = 1'b1;
            x_in   = 18'(SINE[d % 8]);
            @(negedge clk);
        end
        reset  = 1'b1;
        sam_en = 1'b1;
        x_in   = 18'(SINE[2]);
        @(negedge clk);
        reset  = 1'b0;
        sam_en = 1'b0;
        x_in   = '0;
        checks++; if (y !== 18'sd0) begin errors++; $display("FAIL midrst_y: got %0d want 0", y); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL midrst_y_valid: got %b want 0", y_valid); end
        checks++; if (sym_out !== 18'sd0) begin errors++; $display("FAIL midrst_sym_out: got %0d want 0", sym_out); end
        checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL midrst_sym_valid: got %b want 0", sym_valid); end
        checks++; if (dec !== 2'b00) begin errors++; $display("FAIL midrst_dec: got %b want 00", dec); end
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            checks++;
            if (y_valid !== 1'b0) begin
                errors++; $display("FAIL midrst_flush t=%0d: got %b want 0", t, y_valid);
            end
        end
        for (int t = 0; t < 8; t++) begin
            sam_en = (t == 0);
            x_in   = (t == 0) ? 18'sd65536 : 18'sd0;
            @(negedge clk);
            checks++;
            if (y_valid !== (t == 4)) begin
                errors++; $display("FAIL midrst_first_valid t=%0d: got %b want %b", t, y_valid, (t == 4));
            end
            if (t == 4) begin
                checks++;
                if (y !== -18'sd500) begin errors++; $display("FAIL midrst_y_first: got %0d want -500", y); end
                checks++;
                if (sym_valid !== 1'b1) begin errors++; $display("FAIL midrst_phase: got %b want 1", sym_valid); end
                checks++;
                if (sym_out !== -18'sd500) begin errors++; $display("FAIL midrst_sym_out_first: got %0d want -500", sym_out); end
            end
        end
    endtask

    task automatic test_slicer();
        // DC inputs; steady-state y = round(x * 191533 / 2^17)
        logic signed [17:0] xs    [4];
        logic signed [17:0] ys    [4];
        logic [1:0]         decs  [4];
        logic [1:0]         exp_dec;
        xs   = '{-18'sd47904, -18'sd1, 18'sd0, 18'sd47904};
        ys   = '{-18'sd70001, -18'sd1, 18'sd0, 18'sd70001};
        decs = '{2'b00, 2'b01, 2'b10, 2'b11};
        for (int v = 0; v < 4; v++) begin
            do_reset(2);
            sym_phase = 2'd0;
            for (int d = 0; d < 24; d++) begin
                sam_en = 1'b1;
                x_in   = xs[v];
                @(negedge clk);
            end
            sam_en = 1'b0;
            x_in   = '0;
            repeat (6) @(negedge clk);
`ifdef RX_SLICER_EN
            exp_dec = decs[v];
`else
            exp_dec = 2'b00;
`endif
            checks++;
            if (y !== ys[v]) begin errors++; $display("FAIL slicer_y v=%0d: got %0d want %0d", v, y, ys[v]); end
            checks++;
            if (sym_out !== ys[v]) begin errors++; $display("FAIL slicer_sym_out v=%0d: got %0d want %0d", v, sym_out, ys[v]); end
            checks++;
            if (dec !== exp_dec) begin errors++; $display("FAIL slicer_dec v=%0d: got %b want %b", v, dec, exp_dec); end
        end
    endtask

    initial begin
        reset     = 1'b1;
        sam_en    = 1'b0;
        x_in      = '0;
        sym_phase = 2'd0;
        test_reset();
        test_impulse();
        test_gaps();
        test_saturation();
        test_decimation();
        test_reset_midstream();
        test_slicer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
